// File: rtl/h14tx_pkg.sv
// Shared types and link-period constants for the HDMI 1.4 TX period scheduler.
package h14tx_pkg;

    typedef enum logic [2:0] {
        CONTROL,
        VIDEO_PREAMBLE,
        VIDEO_GUARD,
        VIDEO_DATA,
        ISLAND_PREAMBLE,
        ISLAND_GUARD_LEAD,
        ISLAND_DATA,
        ISLAND_GUARD_TRAIL
    } period_t;

    typedef enum logic [2:0] {
        ISL_IDLE,
        ISL_PRE,
        ISL_LGUARD,
        ISL_DATA,
        ISL_TGUARD
    } island_state_t;

    localparam int PreambleLen   = 8;
    localparam int GuardLen      = 2;
    localparam int PacketLen     = 32;
    localparam int MinControlLen = 12;

    function automatic period_t island_period(input island_state_t s);
        case (s)
            ISL_PRE:    return ISLAND_PREAMBLE;
            ISL_LGUARD: return ISLAND_GUARD_LEAD;
            ISL_DATA:   return ISLAND_DATA;
            ISL_TGUARD: return ISLAND_GUARD_TRAIL;
            default:    return CONTROL;
        endcase
    endfunction

endpackage

// File: rtl/h14tx_island_fsm.sv
// Data-island sequencer: preamble, guards and up to MaxPackets packet slots per line,
// with a one-cycle pkt_ready pulse at the start of every slot.
module h14tx_island_fsm
    import h14tx_pkg::*;
#(
    parameter int BitWidth    = 11,
    parameter int IslandStart = 1284,
    parameter int MaxPackets  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BitWidth-1:0] x,
    input  logic                pkt_valid,
    output logic                pkt_ready,
    output period_t             period,
    output logic [4:0]          pkt_index,
    output logic                busy
);

    localparam logic [BitWidth-1:0] StartX = BitWidth'(IslandStart);
    localparam logic [4:0] PreLast   = 5'(PreambleLen - 1);
    localparam logic [4:0] GuardLast = 5'(GuardLen - 1);
    localparam logic [4:0] PktLast   = 5'(PacketLen - 1);
    localparam logic [2:0] SlotMax   = 3'(MaxPackets);

    island_state_t state;
    logic [4:0]    cnt;
    logic [2:0]    slots;

    // The registered state is the period of the cycle just sampled, so it is
    // presented directly as the one-cycle-latency output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ISL_IDLE;
            cnt       <= '0;
            slots     <= '0;
            pkt_ready <= 1'b0;
        end else begin
            pkt_ready <= 1'b0;
            case (state)
                ISL_IDLE: begin
                    if (x == StartX && pkt_valid) begin
                        state <= ISL_PRE;
                        cnt   <= '0;
                        slots <= '0;
                    end
                end
                ISL_PRE: begin
                    if (cnt == PreLast) begin
                        state <= ISL_LGUARD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ISL_LGUARD: begin
                    if (cnt == GuardLast) begin
                        state     <= ISL_DATA;
                        cnt       <= '0;
                        slots     <= 3'd1;
                        pkt_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ISL_DATA: begin
                    if (cnt == PktLast) begin
                        cnt <= '0;
                        if (slots < SlotMax && pkt_valid) begin
                            slots     <= slots + 3'd1;
                            pkt_ready <= 1'b1;
                        end else begin
                            state <= ISL_TGUARD;
                        end
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ISL_TGUARD: begin
                    if (cnt == GuardLast) begin
                        state <= ISL_IDLE;
                        cnt   <= '0;
                        slots <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: begin
                    state <= ISL_IDLE;
                    cnt   <= '0;
                    slots <= '0;
                end
            endcase
        end
    end

    always_comb begin
        period    = island_period(state);
        busy      = (state != ISL_IDLE);
        pkt_index = (state == ISL_DATA) ? cnt : '0;
    end

endmodule

// File: rtl/h14tx_period_scheduler.sv
// HDMI 1.4 TX link-period scheduler: raster decode, video preamble/guard, syncs,
// and data-island scheduling, all with one cycle of latency from the cursor.
module h14tx_period_scheduler
    import h14tx_pkg::*;
#(
    parameter int BitWidth    = 11,
    parameter int BitHeight   = 10,
    parameter int HActive     = 1280,
    parameter int HFront      = 110,
    parameter int HSync       = 40,
    parameter int HBack       = 220,
    parameter int VActive     = 720,
    parameter int VFront      = 5,
    parameter int VSync       = 5,
    parameter int VBack       = 20,
    parameter bit HSyncPol    = 1'b1,
    parameter bit VSyncPol    = 1'b1,
    parameter int IslandStart = HActive + 4,
    parameter int MaxPackets  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BitWidth-1:0]  x,
    input  logic [BitHeight-1:0] y,
    input  logic                 pkt_valid,
    output logic                 pkt_ready,
    output period_t              period,
    output logic [4:0]           pkt_index,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de
);

    localparam int HTotal = HActive + HFront + HSync + HBack;
    localparam int VTotal = VActive + VFront + VSync + VBack;

    if (HTotal >= (1 << BitWidth) || VTotal >= (1 << BitHeight)) begin : g_bad_raster
        $error("raster totals do not fit the cursor widths");
    end
    if (IslandStart + MinControlLen + PacketLen * MaxPackets + MinControlLen > HTotal - 10)
    begin : g_bad_island
        $error("data island would overlap the video preamble");
    end
    if (MaxPackets < 1 || MaxPackets > 4) begin : g_bad_packets
        $error("MaxPackets must be 1..4");
    end

    localparam logic [BitWidth-1:0]  XActEnd     = BitWidth'(HActive);
    localparam logic [BitWidth-1:0]  XHsStart    = BitWidth'(HActive + HFront);
    localparam logic [BitWidth-1:0]  XHsEnd      = BitWidth'(HActive + HFront + HSync);
    localparam logic [BitWidth-1:0]  XPreStart   = BitWidth'(HTotal - 10);
    localparam logic [BitWidth-1:0]  XGuardStart = BitWidth'(HTotal - 2);
    localparam logic [BitWidth-1:0]  XLast       = BitWidth'(HTotal - 1);
    localparam logic [BitHeight-1:0] YActEnd     = BitHeight'(VActive);
    localparam logic [BitHeight-1:0] YVsStart    = BitHeight'(VActive + VFront);
    localparam logic [BitHeight-1:0] YVsEnd      = BitHeight'(VActive + VFront + VSync);
    localparam logic [BitHeight-1:0] YLast       = BitHeight'(VTotal - 1);

    logic [BitHeight-1:0] next_line;
    logic                 next_is_active;
    logic                 in_active;
    logic                 in_hs;
    logic                 in_vs;
    period_t              video_d;

    always_comb begin
        next_line      = (y == YLast) ? '0 : y + BitHeight'(1);
        next_is_active = (next_line < YActEnd);
        in_active      = (x < XActEnd) && (y < YActEnd);
        in_hs          = (x >= XHsStart) && (x < XHsEnd);
        in_vs          = (y >= YVsStart) && (y < YVsEnd);
        video_d        = CONTROL;
        if (in_active) begin
            video_d = VIDEO_DATA;
        end else if (next_is_active && x >= XPreStart && x < XGuardStart) begin
            video_d = VIDEO_PREAMBLE;
        end else if (next_is_active && x >= XGuardStart && x <= XLast) begin
            video_d = VIDEO_GUARD;
        end
    end

    period_t video_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            video_q <= CONTROL;
            de      <= 1'b0;
            hsync   <= ~HSyncPol;
            vsync   <= ~VSyncPol;
        end else begin
            video_q <= video_d;
            de      <= in_active;
            hsync   <= in_hs ? HSyncPol : ~HSyncPol;
            vsync   <= in_vs ? VSyncPol : ~VSyncPol;
        end
    end

    period_t island_q;
    logic    island_busy;

    h14tx_island_fsm #(
        .BitWidth    (BitWidth),
        .IslandStart (IslandStart),
        .MaxPackets  (MaxPackets)
    ) u_island (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .period    (island_q),
        .pkt_index (pkt_index),
        .busy      (island_busy)
    );

    // Islands live wholly in horizontal blanking, so they never contend with video periods.
    assign period = island_busy ? island_q : video_q;

endmodule

// File: tb/tb_h14tx_period_scheduler.sv
// Directed bench for h14tx_period_scheduler: per-cycle comparison against a
// behavioural raster/island model, plus literal per-line expectations.
module tb_h14tx_period_scheduler;
    import h14tx_pkg::*;

    localparam int HA = 1280, HF = 110, HS = 40, HB = 220, HT = 1650;
    localparam int VA = 720,  VF = 5,   VS = 5,  VB = 20,  VT = 750;
    localparam int ISX = HA + 4;
    localparam int MAXP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] x;
    logic [9:0]  y;
    logic        pkt_valid;
    logic        pkt_ready;
    period_t     period;
    logic [4:0]  pkt_index;
    logic        hsync, vsync, de;

    always #5 clk = ~clk;

    h14tx_period_scheduler #(
        .BitWidth (11), .BitHeight (10),
        .HActive (HA), .HFront (HF), .HSync (HS), .HBack (HB),
        .VActive (VA), .VFront (VF), .VSync (VS), .VBack (VB),
        .HSyncPol (1'b1), .VSyncPol (1'b1),
        .IslandStart (ISX), .MaxPackets (MAXP)
    ) dut (
        .clk (clk), .rst (rst), .x (x), .y (y), .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready), .period (period), .pkt_index (pkt_index),
        .hsync (hsync), .vsync (vsync), .de (de)
    );

    typedef struct {
        bit      chk;
        period_t period;
        bit      de, hs, vs, rdy;
        int      idx;
        int      x, y;
    } exp_t;

    exp_t exp_cur, exp_hold;
    int   n_vec = 0, n_err = 0;

    bit m_act;
    int m_off, m_slots;

    int obs_per [0:2047];
    int obs_de  [0:2047];
    int obs_hs  [0:2047];
    int obs_vs  [0:2047];
    int obs_rdy [0:2047];

    task automatic chk(input string name, input int act, input int req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Compare process: capture the expectation at the edge, check outputs mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            exp_hold = exp_cur;
            @(negedge clk);
            if (exp_hold.chk) begin
                n_vec++;
                chk($sformatf("period x=%0d y=%0d", exp_hold.x, exp_hold.y), int'(period), int'(exp_hold.period));
                chk($sformatf("de x=%0d y=%0d", exp_hold.x, exp_hold.y), int'(de), int'(exp_hold.de));
                chk($sformatf("hsync x=%0d y=%0d", exp_hold.x, exp_hold.y), int'(hsync), int'(exp_hold.hs));
                chk($sformatf("vsync x=%0d y=%0d", exp_hold.x, exp_hold.y), int'(vsync), int'(exp_hold.vs));
                chk($sformatf("pkt_ready x=%0d y=%0d", exp_hold.x, exp_hold.y), int'(pkt_ready), int'(exp_hold.rdy));
                chk($sformatf("pkt_index x=%0d y=%0d", exp_hold.x, exp_hold.y), int'(pkt_index), exp_hold.idx);
                obs_per[exp_hold.x] = int'(period);
                obs_de[exp_hold.x]  = int'(de);
                obs_hs[exp_hold.x]  = int'(hsync);
                obs_vs[exp_hold.x]  = int'(vsync);
                obs_rdy[exp_hold.x] = int'(pkt_ready);
            end
        end
    end

    // Apply one cursor cycle and derive what the outputs for it must be.
    task automatic drive(input int xi, input int yi, input bit v, input bit r);
        exp_t e;
        int   nl;
        @(posedge clk);
        #1;
        x = 11'(xi);
        y = 10'(yi);
        pkt_valid = v;
        rst = r;
        e.chk = 1; e.x = xi; e.y = yi;
        e.period = CONTROL; e.de = 0; e.hs = 0; e.vs = 0; e.rdy = 0; e.idx = 0;
        if (r) begin
            m_act = 0;
        end else begin
            nl = (yi + 1) % VT;
            e.de = (xi < HA) && (yi < VA);
            e.hs = (xi >= HA + HF) && (xi < HA + HF + HS);
            e.vs = (yi >= VA + VF) && (yi < VA + VF + VS);
            if (e.de) e.period = VIDEO_DATA;
            else if (nl < VA && xi >= HT - 10 && xi <= HT - 3) e.period = VIDEO_PREAMBLE;
            else if (nl < VA && xi >= HT - 2) e.period = VIDEO_GUARD;
            if (m_act) begin
                m_off++;
                if (m_off == 10 + 32 * m_slots && m_slots < MAXP && v) m_slots++;
                if (m_off >= 12 + 32 * m_slots) m_act = 0;
            end else if (xi == ISX && v) begin
                m_act = 1; m_off = 0; m_slots = 1;
            end
            if (m_act) begin
                if (m_off < 8) e.period = ISLAND_PREAMBLE;
                else if (m_off < 10) e.period = ISLAND_GUARD_LEAD;
                else if (m_off < 10 + 32 * m_slots) begin
                    e.period = ISLAND_DATA;
                    e.idx = (m_off - 10) % 32;
                    e.rdy = (e.idx == 0);
                end else e.period = ISLAND_GUARD_TRAIL;
            end
        end
        exp_cur = e;
    endtask

    // vmode: 0 idle, 1 one packet (valid 1200..1294), 2 continuous, 3 rising at 1285
    task automatic run_line(input int yi, input int x0, input int x1, input int vmode, input int rst_x);
        bit v;
        for (int i = 0; i < 2048; i++) begin
            obs_per[i] = -1; obs_de[i] = 0; obs_hs[i] = 0; obs_vs[i] = 0; obs_rdy[i] = 0;
        end
        for (int xi = x0; xi <= x1; xi++) begin
            case (vmode)
                1:       v = (xi >= 1200 && xi <= 1294);
                2:       v = 1'b1;
                3:       v = (xi >= 1285);
                default: v = 1'b0;
            endcase
            drive(xi, yi, v, xi == rst_x);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        exp_cur.chk = 0;
    endtask

    function automatic int first_x(input int p);
        for (int i = 0; i < 2048; i++) if (obs_per[i] == p) return i;
        return -1;
    endfunction

    function automatic int last_x(input int p);
        for (int i = 2047; i >= 0; i--) if (obs_per[i] == p) return i;
        return -1;
    endfunction

    function automatic int sum_arr(input int which);
        int s = 0;
        for (int i = 0; i < 2048; i++) begin
            case (which)
                0: s += obs_de[i];
                1: s += obs_hs[i];
                2: s += obs_vs[i];
                3: s += obs_rdy[i];
                default: s += (obs_per[i] >= int'(ISLAND_PREAMBLE)) ? 1 : 0;
            endcase
        end
        return s;
    endfunction

    function automatic int nth_ready(input int n);
        int k = 0;
        for (int i = 0; i < 2048; i++) begin
            if (obs_rdy[i] != 0) begin
                if (k == n) return i;
                k++;
            end
        end
        return -1;
    endfunction

    task automatic pin(input string name, input int act, input int req);
        n_vec++;
        chk(name, act, req);
    endtask

    typedef struct { int y; int de_n; int vs_n; int vp_first; } line_t;
    line_t lines [11] = '{
        '{0, 1280, 0, 1640}, '{1, 1280, 0, 1640}, '{718, 1280, 0, 1640},
        '{719, 1280, 0, -1}, '{720, 0, 0, -1},    '{724, 0, 0, -1},
        '{725, 0, 1650, -1}, '{729, 0, 1650, -1}, '{730, 0, 0, -1},
        '{748, 0, 0, -1},    '{749, 0, 0, 1640}
    };

    initial begin
        exp_cur.chk = 0;
        x = '0; y = '0; pkt_valid = 1'b0; rst = 1'b1;
        m_act = 0; m_off = 0; m_slots = 0;

        for (int i = 0; i < 3; i++) drive(0, 0, 1'b0, 1'b1);

        // Idle lines across active, blanking and vsync regions
        foreach (lines[i]) begin
            run_line(lines[i].y, 0, HT - 1, 0, -1);
            pin($sformatf("de_count y=%0d", lines[i].y), sum_arr(0), lines[i].de_n);
            pin($sformatf("hsync_first y=%0d", lines[i].y), first_hs(), 1390);
            pin($sformatf("hsync_count y=%0d", lines[i].y), sum_arr(1), 40);
            pin($sformatf("vsync_count y=%0d", lines[i].y), sum_arr(2), lines[i].vs_n);
            pin($sformatf("vpre_first y=%0d", lines[i].y), first_x(int'(VIDEO_PREAMBLE)), lines[i].vp_first);
            pin($sformatf("vguard_last y=%0d", lines[i].y), last_x(int'(VIDEO_GUARD)),
                lines[i].vp_first < 0 ? -1 : 1649);
            pin($sformatf("island_cycles y=%0d", lines[i].y), sum_arr(4), 0);
        end

        // One packet on a vsync-adjacent blanking line
        run_line(730, 1150, 1449, 1, -1);
        pin("one_pre_first", first_x(int'(ISLAND_PREAMBLE)), 1284);
        pin("one_pre_last", last_x(int'(ISLAND_PREAMBLE)), 1291);
        pin("one_lguard_last", last_x(int'(ISLAND_GUARD_LEAD)), 1293);
        pin("one_data_first", first_x(int'(ISLAND_DATA)), 1294);
        pin("one_data_last", last_x(int'(ISLAND_DATA)), 1325);
        pin("one_ready_count", sum_arr(3), 1);
        pin("one_ready_x", nth_ready(0), 1294);
        pin("one_tguard_last", last_x(int'(ISLAND_GUARD_TRAIL)), 1327);

        // Continuous valid: two slots, third packet waits for the next line
        run_line(100, 1200, 1449, 2, -1);
        pin("cont_ready0", nth_ready(0), 1294);
        pin("cont_ready1", nth_ready(1), 1326);
        pin("cont_ready_count", sum_arr(3), 2);
        pin("cont_tguard_first", first_x(int'(ISLAND_GUARD_TRAIL)), 1358);
        pin("cont_tguard_last", last_x(int'(ISLAND_GUARD_TRAIL)), 1359);
        run_line(101, 1200, 1449, 2, -1);
        pin("cont_next_ready0", nth_ready(0), 1294);

        // Late valid: nothing this line, island on the next
        run_line(200, 1200, HT - 1, 3, -1);
        pin("late_island_cycles", sum_arr(4), 0);
        run_line(201, 1200, 1449, 2, -1);
        pin("late_next_pre_first", first_x(int'(ISLAND_PREAMBLE)), 1284);

        // Reset during packet data abandons the island without a trailing guard
        run_line(300, 1200, 1449, 2, 1300);
        pin("rst_period", obs_per[1300], int'(CONTROL));
        pin("rst_island_cycles", sum_arr(4), 16);
        pin("rst_tguard", first_x(int'(ISLAND_GUARD_TRAIL)), -1);
        run_line(301, 1200, 1449, 2, -1);
        pin("rst_next_pre_first", first_x(int'(ISLAND_PREAMBLE)), 1284);
        pin("rst_next_ready0", nth_ready(0), 1294);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic int first_hs();
        for (int i = 0; i < 2048; i++) if (obs_hs[i] != 0) return i;
        return -1;
    endfunction

endmodule
